// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm-compare/key logic and the ringer.
// The master drives trigger and key pulses; the slave (ringer) drives buzzer and status.
interface alarm_ringer_if;
  logic [1:0] alarm_up;
  logic [4:0] key;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] tone_sel;

  modport master (
    output alarm_up, key,
    input  buzzer, ringing, snoozing, tone_sel
  );

  modport slave (
    input  alarm_up, key,
    output buzzer, ringing, snoozing, tone_sel
  );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm ringer: plays a per-tone beat pattern on the buzzer pin, with stop,
// limited snooze, and auto-stop after a fixed number of beats.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | silent, waiting for a trigger; keys ignored
// S_RING   | buzzer pattern playing for tone_q; counts beats to auto-stop
// S_SNOOZE | silent, counts snooze beats then re-enters S_RING
module alarm_ringer #(
  parameter int TONE1_DIV    = 25000,
  parameter int TONE2_DIV    = 16667,
  parameter int BEAT_CYC     = 12500000,
  parameter int RING_BEATS   = 120,
  parameter int SNOOZE_BEATS = 1200,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic          clk,
  input  logic          rst,
  alarm_ringer_if.slave bus
);

  localparam int MAX_DIV   = (TONE1_DIV > TONE2_DIV) ? TONE1_DIV : TONE2_DIV;
  localparam int MAX_BEATS = (RING_BEATS > SNOOZE_BEATS) ? RING_BEATS : SNOOZE_BEATS;
  localparam int HW = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam int BW = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam int IW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [HW-1:0] T1_LAST   = HW'(TONE1_DIV - 1);
  localparam logic [HW-1:0] T2_LAST   = HW'(TONE2_DIV - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYC - 1);
  localparam logic [IW-1:0] RING_LAST = IW'(RING_BEATS - 1);
  localparam logic [IW-1:0] SNZ_LAST  = IW'(SNOOZE_BEATS - 1);
  localparam logic [SW-1:0] SNZ_MAX   = SW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    tone_q, tone_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [IW-1:0] beat_q, beat_d;
  logic [SW-1:0] snz_q, snz_d;
  logic          buzzer_q, buzzer_d;
  logic          ringing_q, snoozing_q;

  logic          trig, stop_key, snz_key, to_idle, tone_on;
  logic [1:0]    new_tone;
  logic [HW-1:0] half_last;

  always_comb begin
    state_d  = state_q;
    tone_d   = tone_q;
    hcnt_d   = hcnt_q;
    bcnt_d   = bcnt_q;
    beat_d   = beat_q;
    snz_d    = snz_q;
    buzzer_d = 1'b0;
    to_idle  = 1'b0;

    trig      = |bus.alarm_up;
    new_tone  = bus.alarm_up[0] ? 2'd1 : 2'd2;
    stop_key  = |bus.key[3:0];
    snz_key   = bus.key[4];
    // tone 1 is silent on odd beats; tone 2 alternates pitch on odd beats
    tone_on   = (tone_q == 2'd2) || !beat_q[0];
    half_last = ((tone_q == 2'd2) && beat_q[0]) ? T2_LAST : T1_LAST;

    if (trig) begin
      state_d = S_RING;
      tone_d  = new_tone;
      hcnt_d  = '0;
      bcnt_d  = '0;
      beat_d  = '0;
      if (state_q == S_IDLE || tone_q != new_tone) snz_d = '0;
    end else begin
      case (state_q)
        S_RING: begin
          if (stop_key) begin
            to_idle = 1'b1;
          end else if (snz_key) begin
            if (snz_q == SNZ_MAX) begin
              to_idle = 1'b1;
            end else begin
              state_d = S_SNOOZE;
              snz_d   = snz_q + 1'b1;
              hcnt_d  = '0;
              bcnt_d  = '0;
              beat_d  = '0;
            end
          end else if (bcnt_q == BEAT_LAST) begin
            bcnt_d = '0;
            hcnt_d = '0;
            beat_d = beat_q + 1'b1;
            if (beat_q == RING_LAST) to_idle = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
            if (tone_on) begin
              if (hcnt_q == half_last) begin
                hcnt_d   = '0;
                buzzer_d = ~buzzer_q;
              end else begin
                hcnt_d   = hcnt_q + 1'b1;
                buzzer_d = buzzer_q;
              end
            end else begin
              hcnt_d = '0;
            end
          end
        end
        S_SNOOZE: begin
          if (stop_key) begin
            to_idle = 1'b1;
          end else if (bcnt_q == BEAT_LAST) begin
            bcnt_d = '0;
            if (beat_q == SNZ_LAST) begin
              state_d = S_RING;
              beat_d  = '0;
              hcnt_d  = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        default: to_idle = 1'b1;
      endcase
    end

    if (to_idle) begin
      state_d  = S_IDLE;
      tone_d   = 2'd0;
      hcnt_d   = '0;
      bcnt_d   = '0;
      beat_d   = '0;
      buzzer_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tone_q     <= 2'd0;
      hcnt_q     <= '0;
      bcnt_q     <= '0;
      beat_q     <= '0;
      snz_q      <= '0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tone_q     <= tone_d;
      hcnt_q     <= hcnt_d;
      bcnt_q     <= bcnt_d;
      beat_q     <= beat_d;
      snz_q      <= snz_d;
      buzzer_q   <= buzzer_d;
      ringing_q  <= (state_d == S_RING);
      snoozing_q <= (state_d == S_SNOOZE);
    end
  end

  assign bus.buzzer   = buzzer_q;
  assign bus.ringing  = ringing_q;
  assign bus.snoozing = snoozing_q;
  assign bus.tone_sel = tone_q;

endmodule
